// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR16_1002D generator/checker test sequencer.
`timescale 1ns/1ps
package lfsr_pkg;

    localparam int unsigned LFSR_W_DEF  = 8;
    localparam int unsigned SEED_CYCLES = 2;

    typedef enum logic [3:0] {
        IDLE,
        SEED,
        LOCK_WAIT,
        CLEAN,
        INJECT,
        UNLOCK_WAIT,
        RELOCK_WAIT,
        FAIL,
        DONE
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_LOCK_TO   = 3'd1;
    localparam logic [2:0] ERR_NO_UNLOCK = 3'd2;
    localparam logic [2:0] ERR_RELOCK_TO = 3'd3;
    localparam logic [2:0] ERR_LOCK_LOST = 3'd4;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lfsr_check_sequencer_seq_timer.sv
// Loadable down-counter; holds at zero and flags expiry there.
`timescale 1ns/1ps
module seq_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == '0);

endmodule

// File: rtl/lfsr_check_sequencer.sv
// Autonomous seed/lock/corrupt/relock sequencer driving the LFSR generator-checker pair.
`timescale 1ns/1ps
module lfsr_check_sequencer
    import lfsr_pkg::*;
#(
    parameter int unsigned LFSR_W         = LFSR_W_DEF,
    parameter int unsigned LOCK_TIMEOUT   = 64,
    parameter int unsigned UNLOCK_TIMEOUT = 16,
    parameter int unsigned CLEAN_CYCLES   = 32,
    parameter int unsigned CORRUPT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic [7:0]        i_iterations,
    input  logic              i_lock,
    output logic              o_valid,
    output logic              o_soft_rst,
    output logic [LFSR_W-1:0] o_seed,
    output logic              o_corrupt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [2:0]        o_err_code,
    output logic [7:0]        o_iter_cnt
);

    localparam int unsigned TMAX = umax(umax(LOCK_TIMEOUT, UNLOCK_TIMEOUT),
                                        umax(CLEAN_CYCLES, SEED_CYCLES));
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] T_SEED      = TW'(SEED_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK      = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_CLEAN     = TW'(CLEAN_CYCLES - 1);
    localparam logic [TW-1:0] T_UNLOCK    = TW'(UNLOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_BURST_END = TW'(UNLOCK_TIMEOUT - CORRUPT_CYCLES);

    state_t             r_state;
    logic               r_start_prev;
    logic               r_valid;
    logic               r_soft_rst;
    logic               r_corrupt;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [2:0]         r_err;
    logic [7:0]         r_iter;
    logic [7:0]         r_iter_lim;
    logic [LFSR_W-1:0]  r_seed;

    state_t             w_state_nxt;
    logic               w_start_rise;
    logic               w_tmr_load;
    logic [TW-1:0]      w_tmr_val;
    logic [TW-1:0]      w_tmr_cnt;
    logic               w_tmr_exp;
    logic               w_pass_nxt;
    logic [2:0]         w_err_nxt;
    logic [7:0]         w_iter_nxt;
    logic [7:0]         w_lim_nxt;
    logic [LFSR_W-1:0]  w_seed_nxt;
    logic               w_valid_nxt;
    logic               w_soft_nxt;
    logic               w_corrupt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    assign w_start_rise = i_start & ~r_start_prev;

    seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_count    (w_tmr_cnt),
        .o_expired  (w_tmr_exp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_seed_nxt  = r_seed;
        w_lim_nxt   = r_iter_lim;
        w_iter_nxt  = r_iter;
        w_err_nxt   = r_err;
        w_pass_nxt  = r_pass;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_rise) begin
                    w_state_nxt = SEED;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = T_SEED;
                    w_seed_nxt  = i_seed;
                    w_lim_nxt   = i_iterations;
                    w_iter_nxt  = '0;
                    w_err_nxt   = ERR_NONE;
                    w_pass_nxt  = 1'b0;
                end
            end
            SEED: begin
                if (w_tmr_exp) begin
                    w_state_nxt = LOCK_WAIT;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = T_LOCK;
                end
            end
            LOCK_WAIT: begin
                if (i_lock) begin
                    w_state_nxt = CLEAN;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = T_CLEAN;
                end else if (w_tmr_exp) begin
                    w_state_nxt = FAIL;
                    w_err_nxt   = ERR_LOCK_TO;
                end
            end
            CLEAN: begin
                if (!i_lock) begin
                    w_state_nxt = FAIL;
                    w_err_nxt   = ERR_LOCK_LOST;
                end else if (w_tmr_exp) begin
                    if (r_iter == r_iter_lim) begin
                        w_state_nxt = DONE;
                        w_pass_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = INJECT;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = T_UNLOCK;
                    end
                end
            end
            // One timer spans INJECT and UNLOCK_WAIT; the burst ends at a fixed count within it.
            INJECT, UNLOCK_WAIT: begin
                if (!i_lock) begin
                    w_state_nxt = RELOCK_WAIT;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = T_LOCK;
                end else if (w_tmr_exp) begin
                    w_state_nxt = FAIL;
                    w_err_nxt   = ERR_NO_UNLOCK;
                end else if (r_state == INJECT && w_tmr_cnt == T_BURST_END) begin
                    w_state_nxt = UNLOCK_WAIT;
                end
            end
            RELOCK_WAIT: begin
                if (i_lock) begin
                    w_state_nxt = CLEAN;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = T_CLEAN;
                    if (r_iter != 8'hFF) begin
                        w_iter_nxt = r_iter + 8'd1;
                    end
                end else if (w_tmr_exp) begin
                    w_state_nxt = FAIL;
                    w_err_nxt   = ERR_RELOCK_TO;
                end
            end
            FAIL: begin
                w_state_nxt = DONE;
                w_pass_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_valid_nxt   = (w_state_nxt == LOCK_WAIT) || (w_state_nxt == CLEAN) ||
                        (w_state_nxt == INJECT) || (w_state_nxt == UNLOCK_WAIT) ||
                        (w_state_nxt == RELOCK_WAIT);
        w_soft_nxt    = (w_state_nxt == SEED);
        w_corrupt_nxt = (w_state_nxt == INJECT);
        w_busy_nxt    = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done_nxt    = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b0;
            r_valid      <= 1'b0;
            r_soft_rst   <= 1'b0;
            r_corrupt    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= ERR_NONE;
            r_iter       <= '0;
            r_iter_lim   <= '0;
            r_seed       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_prev <= i_start;
            r_valid      <= w_valid_nxt;
            r_soft_rst   <= w_soft_nxt;
            r_corrupt    <= w_corrupt_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err        <= w_err_nxt;
            r_iter       <= w_iter_nxt;
            r_iter_lim   <= w_lim_nxt;
            r_seed       <= w_seed_nxt;
        end
    end

    assign o_valid    = r_valid;
    assign o_soft_rst = r_soft_rst;
    assign o_seed     = r_seed;
    assign o_corrupt  = r_corrupt;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_err_code = r_err;
    assign o_iter_cnt = r_iter;

endmodule

// File: tb/tb_lfsr_check_sequencer.sv
// Randomised bench: behavioural checker lock model plus per-run outcome/duration prediction.
`timescale 1ns/1ps
module tb_lfsr_check_sequencer;

    localparam int LT = 64;
    localparam int UT = 16;
    localparam int CC = 32;
    localparam int CY = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_seed;
    logic [7:0] i_iterations;
    logic       i_lock = 1'b0;
    logic       o_valid, o_soft_rst, o_corrupt, o_busy, o_done, o_pass;
    logic [7:0] o_seed;
    logic [2:0] o_err_code;
    logic [7:0] o_iter_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int k_dl = 1, k_du = 1, k_dr = 1, k_drop = 0;

    always #5 clk = ~clk;

    lfsr_check_sequencer #(
        .LFSR_W         (8),
        .LOCK_TIMEOUT   (LT),
        .UNLOCK_TIMEOUT (UT),
        .CLEAN_CYCLES   (CC),
        .CORRUPT_CYCLES (CY)
    ) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_seed       (i_seed),
        .i_iterations (i_iterations),
        .i_lock       (i_lock),
        .o_valid      (o_valid),
        .o_soft_rst   (o_soft_rst),
        .o_seed       (o_seed),
        .o_corrupt    (o_corrupt),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_err_code   (o_err_code),
        .o_iter_cnt   (o_iter_cnt)
    );

    // Checker stand-in: locks after k_dl (first) / k_dr (later) clean valid cycles,
    // loses lock k_du cycles after corruption first appears, optional one-cycle drop.
    bit m_locked, m_first;
    int m_cnt, m_lat, m_clean;
    always @(negedge clk) begin
        if (!rst_n || o_soft_rst) begin
            m_locked = 1'b0; m_first = 1'b1;
            m_cnt = 0; m_lat = 0; m_clean = 0;
            i_lock = 1'b0;
        end else if (!m_locked) begin
            m_cnt = (o_valid && !o_corrupt) ? m_cnt + 1 : 0;
            if (m_cnt > 0 && m_cnt >= (m_first ? k_dl : k_dr)) begin
                m_locked = 1'b1; m_lat = 0; m_clean = 0;
            end
            i_lock = m_locked;
        end else begin
            if (m_lat > 0 || o_corrupt) begin
                m_lat++;
                m_first = 1'b0;
            end
            if (m_first && o_valid && !o_corrupt) m_clean++;
            if (m_lat == k_du) begin
                m_locked = 1'b0; m_cnt = 0;
            end
            i_lock = m_locked && !(m_first && k_drop != 0 && m_clean == k_drop);
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_case(input string name, input logic [7:0] seed, input int n,
                            input int dl, input int du, input int dr, input int drop);
        int e_busy, e_pulses, e_ccyc, e_iter, e_err;
        int busy_c, soft_c, pulses, ccyc, done;
        logic prev_c;

        e_busy = SEED_LEN(); e_pulses = 0; e_ccyc = 0; e_iter = 0; e_err = 0;
        if (dl > LT) begin
            e_busy += LT + 1; e_err = 1;
        end else begin
            e_busy += dl;
            if (drop > 0) begin
                e_busy += drop + 1; e_err = 4;
            end else begin
                e_busy += CC;
                for (int i = 0; i < n; i++) begin
                    e_pulses++;
                    if (du > UT) begin
                        e_ccyc += CY; e_busy += UT + 1; e_err = 2;
                        break;
                    end
                    e_ccyc += (du < CY) ? du : CY;
                    e_busy += du;
                    if (dr > LT) begin
                        e_busy += LT + 1; e_err = 3;
                        break;
                    end
                    e_busy += dr + CC;
                    e_iter++;
                end
            end
        end

        k_dl = dl; k_du = du; k_dr = dr; k_drop = drop;
        busy_c = 0; soft_c = 0; pulses = 0; ccyc = 0; done = 0; prev_c = 1'b0;
        @(negedge clk);
        i_seed = seed; i_iterations = 8'(n); i_start = 1'b1;
        for (int c = 0; c < 6000 && done == 0; c++) begin
            @(negedge clk);
            case (c)
                0: begin i_start = 1'b0; i_seed = ~seed; i_iterations = 8'(n + 3); end
                1: i_start = 1'b1;
                2: i_start = 1'b0;
                default: ;
            endcase
            busy_c += int'(o_busy);
            soft_c += int'(o_soft_rst);
            if (o_corrupt && !prev_c) pulses++;
            ccyc  += int'(o_corrupt);
            prev_c = o_corrupt;
            if (o_done) done = 1;
        end
        check_eq($sformatf("%s:done", name), done, 1);
        check_eq($sformatf("%s:pass", name), int'(o_pass), (e_err == 0) ? 1 : 0);
        check_eq($sformatf("%s:err", name), int'(o_err_code), e_err);
        check_eq($sformatf("%s:iter", name), int'(o_iter_cnt), e_iter);
        check_eq($sformatf("%s:seed", name), int'(o_seed), int'(seed));
        check_eq($sformatf("%s:busy_cycles", name), busy_c, e_busy);
        check_eq($sformatf("%s:soft_cycles", name), soft_c, SEED_LEN());
        check_eq($sformatf("%s:pulses", name), pulses, e_pulses);
        check_eq($sformatf("%s:corrupt_cycles", name), ccyc, e_ccyc);
        check_eq($sformatf("%s:valid_in_done", name), int'(o_valid), 0);
        check_eq($sformatf("%s:busy_in_done", name), int'(o_busy), 0);
    endtask

    function automatic int SEED_LEN();
        return 2;
    endfunction

    task automatic reset_mid_inject();
        int seen;
        seen = 0;
        k_dl = 3; k_du = 3; k_dr = 5; k_drop = 0;
        @(negedge clk);
        i_seed = 8'h5A; i_iterations = 8'd2; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 300 && seen == 0; c++) begin
            @(negedge clk);
            if (o_corrupt) seen = 1;
        end
        check_eq("rstmid:inject_reached", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstmid:corrupt", int'(o_corrupt), 0);
        check_eq("rstmid:valid", int'(o_valid), 0);
        check_eq("rstmid:busy", int'(o_busy), 0);
        check_eq("rstmid:seed", int'(o_seed), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_seed = '0; i_iterations = '0;
        #23;
        check_eq("reset:busy", int'(o_busy), 0);
        check_eq("reset:done", int'(o_done), 0);
        check_eq("reset:valid", int'(o_valid), 0);
        check_eq("reset:seed", int'(o_seed), 0);
        check_eq("reset:err", int'(o_err_code), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_case("plan",      8'hA5, 3, 5,    2,    6,    0);
        run_case("lock_to",   8'h3C, 2, 1000, 2,    6,    0);
        run_case("no_unlock", 8'h11, 2, 4,    1000, 6,    0);
        run_case("lock_lost", 8'h22, 2, 4,    2,    6,    10);
        run_case("zero_iter", 8'h33, 0, 7,    2,    6,    0);
        run_case("relock_to", 8'h44, 2, 3,    3,    1000, 0);
        run_case("edge_tmo",  8'h55, 1, LT,   UT,   LT,   0);
        reset_mid_inject();
        run_case("post_rst",  8'h66, 1, 2,    5,    4,    0);

        for (int r = 0; r < 16; r++) begin
            int n, dl, du, dr, drop;
            n    = $urandom_range(0, 4);
            dl   = $urandom_range(1, 70);
            du   = $urandom_range(1, 18);
            dr   = $urandom_range(1, 70);
            drop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, CC) : 0;
            run_case($sformatf("rnd%0d", r), 8'($urandom), n, dl, du, dr, drop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
